// File: rtl/expression_pkg.sv
// Shared widths, watchdog default and FSM encoding for the expression sweep master.
package expression_pkg;

  localparam int unsigned XW_DEF      = 8;
  localparam int unsigned RW_DEF      = 16;
  localparam int unsigned CW_DEF      = 9;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned WD_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RECORD = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/sweep_stats.sv
// Running sweep statistics: saturating sample/overflow counts, first root, unsigned minimum.
module sweep_stats
  import expression_pkg::*;
#(
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          rec_i,
  input  logic [XW-1:0] x_i,
  input  logic [RW-1:0] result_i,
  input  logic          zero_i,
  input  logic          ovf_i,
  output logic [CW-1:0] smp_count_o,
  output logic [CW-1:0] ovf_count_o,
  output logic          root_found_o,
  output logic [XW-1:0] root_x_o,
  output logic          min_valid_o,
  output logic [RW-1:0] min_result_o,
  output logic [XW-1:0] min_x_o
);

  logic [CW-1:0] smp_cnt_q, smp_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic          root_q, root_d, min_v_q, min_v_d;
  logic [XW-1:0] root_x_q, root_x_d, min_x_q, min_x_d;
  logic [RW-1:0] min_r_q, min_r_d;

  // Fold one recorded sample into the statistics; clear wins over record.
  always_comb begin
    smp_cnt_d = smp_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    root_d    = root_q;
    root_x_d  = root_x_q;
    min_v_d   = min_v_q;
    min_r_d   = min_r_q;
    min_x_d   = min_x_q;
    if (clear_i) begin
      smp_cnt_d = '0;
      ovf_cnt_d = '0;
      root_d    = 1'b0;
      root_x_d  = '0;
      min_v_d   = 1'b0;
      min_r_d   = '0;
      min_x_d   = '0;
    end else if (rec_i) begin
      if (smp_cnt_q != '1) smp_cnt_d = smp_cnt_q + CW'(1);
      if (ovf_i && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CW'(1);
      if (zero_i && !root_q) begin
        root_d   = 1'b1;
        root_x_d = x_i;
      end
      if (!ovf_i && (!min_v_q || (result_i < min_r_q))) begin
        min_v_d = 1'b1;
        min_r_d = result_i;
        min_x_d = x_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_cnt_q <= '0;
      ovf_cnt_q <= '0;
      root_q    <= 1'b0;
      root_x_q  <= '0;
      min_v_q   <= 1'b0;
      min_r_q   <= '0;
      min_x_q   <= '0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      root_q    <= root_d;
      root_x_q  <= root_x_d;
      min_v_q   <= min_v_d;
      min_r_q   <= min_r_d;
      min_x_q   <= min_x_d;
    end
  end

  assign smp_count_o  = smp_cnt_q;
  assign ovf_count_o  = ovf_cnt_q;
  assign root_found_o = root_q;
  assign root_x_o     = root_x_q;
  assign min_valid_o  = min_v_q;
  assign min_result_o = min_r_q;
  assign min_x_o      = min_x_q;

endmodule

// File: rtl/expression_sweep_master.sv
// Sweeps X over a programmed range, one solver start/completed handshake per X.
// Optional per-operation watchdog: define EXPRESSION_SWEEP_WATCHDOG_EN.
module expression_sweep_master
  import expression_pkg::*;
#(
  parameter int unsigned XW      = XW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [XW-1:0] x_first,
  input  logic [XW-1:0] x_last,
  input  logic [XW-1:0] x_step,
  output logic          sol_start,
  output logic [XW-1:0] sol_x,
  input  logic [RW-1:0] sol_result,
  input  logic          sol_zero,
  input  logic          sol_overflow,
  input  logic          sol_completed,
  output logic          busy,
  output logic          done,
  output logic          smp_valid,
  output logic [XW-1:0] smp_x,
  output logic [RW-1:0] smp_result,
  output logic          smp_zero,
  output logic          smp_ovf,
  output logic          root_found,
  output logic [XW-1:0] root_x,
  output logic          min_valid,
  output logic [RW-1:0] min_result,
  output logic [XW-1:0] min_x,
  output logic [CW-1:0] smp_count,
  output logic [CW-1:0] ovf_count,
  output logic          timeout_err
);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, last_q, last_d, step_q, step_d;
  logic          sol_start_q, sol_start_d, busy_q, busy_d, done_q, done_d;
  logic          smp_valid_q, smp_valid_d, smp_zero_q, smp_zero_d, smp_ovf_q, smp_ovf_d;
  logic [XW-1:0] smp_x_q, smp_x_d;
  logic [RW-1:0] smp_result_q, smp_result_d;
  logic          clear_c, rec_c, wd_expire_c;
  logic [XW:0]   sum_c;

  // One extra bit so a step past the top of the X range is seen as a carry, never a wrap.
  assign sum_c = {1'b0, x_q} + {1'b0, step_q};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    last_d       = last_q;
    step_d       = step_q;
    smp_valid_d  = 1'b0;
    smp_x_d      = smp_x_q;
    smp_result_d = smp_result_q;
    smp_zero_d   = smp_zero_q;
    smp_ovf_d    = smp_ovf_q;
    clear_c      = 1'b0;
    rec_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          last_d  = x_last;
          step_d  = (x_step == '0) ? XW'(1) : x_step;
          x_d     = x_first;
          clear_c = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_ARM;
      // Completion is ignored here so a level left over from the last op is not reused.
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (sol_completed)    state_d = ST_RECORD;
        else if (wd_expire_c) state_d = ST_DONE;
      end
      ST_RECORD: begin
        rec_c        = 1'b1;
        smp_valid_d  = 1'b1;
        smp_x_d      = x_q;
        smp_result_d = sol_result;
        smp_zero_d   = sol_zero;
        smp_ovf_d    = sol_overflow;
        if ((x_q >= last_q) || sum_c[XW] || (sum_c[XW-1:0] > last_q)) begin
          state_d = ST_DONE;
        end else begin
          x_d     = sum_c[XW-1:0];
          state_d = ST_ISSUE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    sol_start_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      last_q       <= '0;
      step_q       <= '0;
      sol_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      smp_valid_q  <= 1'b0;
      smp_x_q      <= '0;
      smp_result_q <= '0;
      smp_zero_q   <= 1'b0;
      smp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      last_q       <= last_d;
      step_q       <= step_d;
      sol_start_q  <= sol_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      smp_valid_q  <= smp_valid_d;
      smp_x_q      <= smp_x_d;
      smp_result_q <= smp_result_d;
      smp_zero_q   <= smp_zero_d;
      smp_ovf_q    <= smp_ovf_d;
    end
  end

  sweep_stats #(.XW(XW), .RW(RW), .CW(CW)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_c),
    .rec_i        (rec_c),
    .x_i          (x_q),
    .result_i     (sol_result),
    .zero_i       (sol_zero),
    .ovf_i        (sol_overflow),
    .smp_count_o  (smp_count),
    .ovf_count_o  (ovf_count),
    .root_found_o (root_found),
    .root_x_o     (root_x),
    .min_valid_o  (min_valid),
    .min_result_o (min_result),
    .min_x_o      (min_x)
  );

`ifdef EXPRESSION_SWEEP_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  assign wd_expire_c = (state_q == ST_WAIT) && !sol_completed && (wd_q == WD_W'(TIMEOUT - 1));

  // Cycle counter restarts on every entry to WAIT; the error flag is sticky until the next go.
  always_comb begin
    wd_d      = '0;
    timeout_d = timeout_q;
    if (state_q == ST_WAIT) wd_d = wd_q + WD_W'(1);
    if (clear_c)          timeout_d = 1'b0;
    else if (wd_expire_c) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign wd_expire_c    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign sol_start  = sol_start_q;
  assign sol_x      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign smp_valid  = smp_valid_q;
  assign smp_x      = smp_x_q;
  assign smp_result = smp_result_q;
  assign smp_zero   = smp_zero_q;
  assign smp_ovf    = smp_ovf_q;

endmodule

// File: tb/tb_expression_sweep_master.sv
// Scoreboard bench for expression_sweep_master with a reactive solver model.
module tb_expression_sweep_master;

  localparam int XW = 8;
  localparam int RW = 16;
  localparam int CW = 9;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [XW-1:0] x_first = '0, x_last = '0, x_step = '0;
  logic          sol_start, sol_zero, sol_overflow, sol_completed;
  logic [XW-1:0] sol_x, smp_x, root_x, min_x;
  logic [RW-1:0] sol_result, smp_result, min_result;
  logic          busy, done, smp_valid, smp_zero, smp_ovf, root_found, min_valid, timeout_err;
  logic [CW-1:0] smp_count, ovf_count;

  always #5 clk = ~clk;

  expression_sweep_master dut (
    .clk(clk), .rst(rst), .go(go), .x_first(x_first), .x_last(x_last), .x_step(x_step),
    .sol_start(sol_start), .sol_x(sol_x), .sol_result(sol_result), .sol_zero(sol_zero),
    .sol_overflow(sol_overflow), .sol_completed(sol_completed), .busy(busy), .done(done),
    .smp_valid(smp_valid), .smp_x(smp_x), .smp_result(smp_result), .smp_zero(smp_zero),
    .smp_ovf(smp_ovf), .root_found(root_found), .root_x(root_x), .min_valid(min_valid),
    .min_result(min_result), .min_x(min_x), .smp_count(smp_count), .ovf_count(ovf_count),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int            x;
    logic [RW-1:0] r;
    logic          z;
    logic          o;
  } smp_t;

  smp_t exp_q[$];
  int   checks = 0, passes = 0;
  int   cyc = 0;
  int   n_starts = 0, n_done = 0, max_x = -1, last_start_cyc = 0, done_cyc = 0, smp_cyc = 0;
  int   mdl_lat = 2, res_mode = 0, ovf_x = -1;
  bit   mdl_hold = 1'b0, mdl_never = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void sol_fn(input int x, output logic [RW-1:0] r, output logic z, output logic o);
    if (res_mode == 1) r = RW'((x > 5) ? x - 5 : 5 - x);
    else               r = RW'(x * 257 + 3);
    z = (r == '0);
    o = (x == ovf_x);
  endfunction

  // Solver: answers mdl_lat cycles after start; in hold mode the old completion stays up
  // through ISSUE and ARM before dropping.
  initial begin : solver
    int age;
    bit pend;
    int cx;
    sol_completed = 1'b0; sol_result = '0; sol_zero = 1'b0; sol_overflow = 1'b0;
    age = 0; pend = 1'b0; cx = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sol_completed = 1'b0;
        pend = 1'b0;
      end else if (sol_start) begin
        pend = 1'b1; age = 0; cx = int'(sol_x);
        if (!mdl_hold) sol_completed = 1'b0;
      end else if (pend) begin
        age++;
        if (mdl_hold && age == 2) sol_completed = 1'b0;
        if (!mdl_never && age >= mdl_lat) begin
          sol_fn(cx, sol_result, sol_zero, sol_overflow);
          sol_completed = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    smp_t e;
    forever begin
      @(negedge clk);
      if (sol_start) begin
        n_starts++;
        last_start_cyc = cyc;
        if (int'(sol_x) > max_x) max_x = int'(sol_x);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (smp_valid) begin
        smp_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sample_unexpected: got x=%0d r=%0d, required no sample", smp_x, smp_result);
        end else begin
          e = exp_q.pop_front();
          if (smp_x !== XW'(e.x) || smp_result !== e.r || smp_zero !== e.z || smp_ovf !== e.o)
            $display("FAIL sample: got x=%0d r=%0d z=%0b o=%0b, required x=%0d r=%0d z=%0b o=%0b",
                     smp_x, smp_result, smp_zero, smp_ovf, e.x, e.r, e.z, e.o);
          else passes++;
        end
      end
    end
  end

  // Reference sweep: expected sample sequence for the given bounds.
  task automatic push_expected(input int f, input int l, input int s);
    int x, st, nx;
    smp_t e;
    st = (s == 0) ? 1 : s;
    x = f;
    forever begin
      e.x = x;
      sol_fn(x, e.r, e.z, e.o);
      exp_q.push_back(e);
      if (x >= l) break;
      nx = x + st;
      if (nx > (1 << XW) - 1 || nx > l) break;
      x = nx;
    end
  endtask

  task automatic run_sweep(input int f, input int l, input int s, input int mid_go, input int budget,
                           output logic busy1, output logic busy_end);
    bit ok;
    n_starts = 0; max_x = -1;
    @(negedge clk);
    x_first = XW'(f); x_last = XW'(l); x_step = XW'(s); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    busy1 = busy;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      go = (i == mid_go);
      @(negedge clk);
    end
    go = 1'b0;
    busy_end = busy;
    checks++;
    if (!ok) $display("FAIL done_wait: no done within %0d cycles, required done", budget);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sol_start, busy, done, smp_valid, root_found, min_valid, timeout_err, smp_zero, smp_ovf} !== 9'b0)
      $display("FAIL reset_flags: got %b, required 0",
               {sol_start, busy, done, smp_valid, root_found, min_valid, timeout_err, smp_zero, smp_ovf});
    else passes++;
    checks++;
    if ({sol_x, smp_x, root_x, min_x, smp_result, min_result, smp_count, ovf_count} !== '0)
      $display("FAIL reset_values: got sol_x=%0d smp_count=%0d min_result=%0d, required 0",
               sol_x, smp_count, min_result);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic b1, be;
    mdl_lat = 2; res_mode = 0; ovf_x = -1;
    push_expected(3, 3, 1);
    run_sweep(3, 3, 1, -1, 50, b1, be);
    checks++; if (n_starts !== 1) $display("FAIL single_starts: got %0d, required 1", n_starts); else passes++;
    checks++; if (smp_count !== 9'd1) $display("FAIL single_count: got %0d, required 1", smp_count); else passes++;
    checks++; if (done_cyc - last_start_cyc !== 4)
      $display("FAIL single_latency: got start->done %0d, required 4", done_cyc - last_start_cyc); else passes++;
    checks++; if (smp_cyc !== done_cyc)
      $display("FAIL single_align: got smp cycle %0d done cycle %0d, required equal", smp_cyc, done_cyc); else passes++;
    checks++; if ({b1, be} !== 2'b10) $display("FAIL single_busy: got issue/done %b, required 10", {b1, be}); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL single_left: got %0d pending, required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_step_sweep();
    logic b1, be;
    push_expected(0, 10, 3);
    run_sweep(0, 10, 3, -1, 100, b1, be);
    checks++; if (n_starts !== 4) $display("FAIL step_starts: got %0d, required 4", n_starts); else passes++;
    checks++; if (smp_count !== 9'd4) $display("FAIL step_count: got %0d, required 4", smp_count); else passes++;
    checks++; if (max_x !== 9) $display("FAIL step_max_x: got %0d, required 9", max_x); else passes++;
  endtask

  task automatic test_no_wrap();
    logic b1, be;
    push_expected(250, 255, 4);
    run_sweep(250, 255, 4, -1, 100, b1, be);
    checks++; if (n_starts !== 2) $display("FAIL wrap_starts: got %0d, required 2", n_starts); else passes++;
    checks++; if (smp_count !== 9'd2) $display("FAIL wrap_count: got %0d, required 2", smp_count); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL wrap_left: got %0d pending, required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reverse_and_zero_step();
    logic b1, be;
    push_expected(20, 5, 1);
    run_sweep(20, 5, 1, -1, 50, b1, be);
    checks++; if (smp_count !== 9'd1 || n_starts !== 1)
      $display("FAIL reverse_count: got %0d samples %0d starts, required 1/1", smp_count, n_starts); else passes++;
    push_expected(0, 3, 0);
    run_sweep(0, 3, 0, -1, 100, b1, be);
    checks++; if (smp_count !== 9'd4) $display("FAIL zero_step_count: got %0d, required 4", smp_count); else passes++;
  endtask

  task automatic test_stats();
    logic b1, be;
    res_mode = 1; ovf_x = 7;
    push_expected(0, 9, 1);
    run_sweep(0, 9, 1, -1, 200, b1, be);
    checks++; if ({root_found, root_x} !== {1'b1, 8'd5})
      $display("FAIL stats_root: got found=%0b x=%0d, required 1/5", root_found, root_x); else passes++;
    checks++; if ({min_valid, min_result, min_x} !== {1'b1, 16'd0, 8'd5})
      $display("FAIL stats_min: got v=%0b r=%0d x=%0d, required 1/0/5", min_valid, min_result, min_x); else passes++;
    checks++; if (ovf_count !== 9'd1) $display("FAIL stats_ovf: got %0d, required 1", ovf_count); else passes++;
    checks++; if (smp_count !== 9'd10) $display("FAIL stats_count: got %0d, required 10", smp_count); else passes++;
    res_mode = 0; ovf_x = -1;
  endtask

  task automatic test_hold_completed();
    logic b1, be;
    mdl_hold = 1'b1; mdl_lat = 4;
    push_expected(10, 14, 1);
    run_sweep(10, 14, 1, 8, 200, b1, be);
    checks++; if (n_starts !== 5) $display("FAIL hold_starts: got %0d, required 5", n_starts); else passes++;
    checks++; if (smp_count !== 9'd5) $display("FAIL hold_count: got %0d, required 5", smp_count); else passes++;
    checks++; if (min_x !== 8'd10) $display("FAIL hold_min_x: got %0d, required 10", min_x); else passes++;
    mdl_hold = 1'b0; mdl_lat = 2;
  endtask

  task automatic test_go_at_done();
    bit ok;
    push_expected(40, 41, 1);
    n_starts = 0;
    @(negedge clk);
    x_first = 8'd40; x_last = 8'd41; x_step = 8'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++; if (!ok) $display("FAIL done_go_wait: no done, required done"); else passes++;
    checks++; if ({busy, sol_start} !== 2'b00)
      $display("FAIL done_go_busy: got busy/start %b, required 00", {busy, sol_start}); else passes++;
    repeat (6) @(negedge clk);
    checks++; if (n_starts !== 2) $display("FAIL done_go_starts: got %0d, required 2", n_starts); else passes++;
  endtask

  task automatic test_reset_mid_sweep();
    int done_before;
    bit ok;
    mdl_lat = 2;
    push_expected(0, 5, 1);
    @(negedge clk);
    x_first = 8'd0; x_last = 8'd5; x_step = 8'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (smp_count == 9'd2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    mdl_never = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (!ok || busy !== 1'b1 || smp_count !== 9'd2)
      $display("FAIL rst_pre: got busy=%0b count=%0d, required 1/2", busy, smp_count); else passes++;
    done_before = n_done;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({sol_start, busy, done, smp_valid, root_found, min_valid, timeout_err} !== 7'b0 ||
        {sol_x, smp_x, smp_result, min_result, min_x, smp_count, ovf_count} !== '0)
      $display("FAIL rst_async: got busy=%0b sol_x=%0d count=%0d min_valid=%0b, required 0",
               busy, sol_x, smp_count, min_valid);
    else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    mdl_never = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (n_done !== done_before || busy !== 1'b0)
      $display("FAIL rst_no_done: got %0d extra done busy=%0b, required 0/0", n_done - done_before, busy); else passes++;
  endtask

`ifdef EXPRESSION_SWEEP_WATCHDOG_EN
  task automatic test_watchdog();
    logic b1, be;
    int lat;
    mdl_never = 1'b1;
    run_sweep(0, 3, 1, -1, TIMEOUT + 40, b1, be);
    lat = done_cyc - last_start_cyc;
    checks++; if (timeout_err !== 1'b1) $display("FAIL wd_err: got %0b, required 1", timeout_err); else passes++;
    checks++; if (smp_count !== 9'd0 || n_starts !== 1)
      $display("FAIL wd_samples: got %0d samples %0d starts, required 0/1", smp_count, n_starts); else passes++;
    checks++; if (lat < TIMEOUT || lat > TIMEOUT + 4)
      $display("FAIL wd_latency: got %0d, required %0d..%0d", lat, TIMEOUT, TIMEOUT + 4); else passes++;
    mdl_never = 1'b0;
    push_expected(7, 7, 1);
    run_sweep(7, 7, 1, -1, 50, b1, be);
    checks++; if ({timeout_err, smp_count} !== {1'b0, 9'd1})
      $display("FAIL wd_clear: got err=%0b count=%0d, required 0/1", timeout_err, smp_count); else passes++;
  endtask
`endif

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_step_sweep();
    test_no_wrap();
    test_reverse_and_zero_step();
    test_stats();
    test_hold_completed();
    test_go_at_done();
`ifdef EXPRESSION_SWEEP_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/expression_sweep_master.md
Name: expression_sweep_master

Overview:
- Initiator-side sequencer for the expression solver's start/completed handshake.
- Sweeps X over a host-programmed range and issues one solver operation per X value.
- Captures each result/zero/overflow response, streams every sample out, and keeps running statistics.
- Sits between the host/control logic and one solver instance; holds no A/B/C operands, which are wired to the solver directly.

Parameters:
- XW, 8, width of X and of the sweep bounds.
- RW, 16, width of the solver result.
- CW, 9, width of the sample and overflow counters (must hold 2^XW).
- TIMEOUT, 255, watchdog limit in cycles per operation (used only with the watchdog feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- go  in  1  one-cycle request to begin a sweep; ignored unless busy=0
- x_first  in  XW  first X, sampled on an accepted go
- x_last  in  XW  last X bound, sampled on an accepted go
- x_step  in  XW  X increment, sampled on an accepted go; 0 is treated as 1
- sol_start  out  1  one-cycle start pulse to the solver
- sol_x  out  XW  X operand; held stable from ISSUE until RECORD
- sol_result  in  RW  solver result
- sol_zero  in  1  solver zero flag
- sol_overflow  in  1  solver overflow flag
- sol_completed  in  1  solver completion level
- busy  out  1  high from the cycle after an accepted go until done
- done  out  1  one-cycle pulse when the sweep ends
- smp_valid  out  1  one-cycle pulse per captured sample
- smp_x, smp_result  out  XW, RW  the captured sample
- smp_zero, smp_ovf  out  1, 1  flags of the captured sample
- root_found  out  1  at least one sample had zero=1
- root_x  out  XW  X of the first zero sample
- min_valid  out  1  at least one non-overflow sample was captured
- min_result, min_x  out  RW, XW  smallest unsigned non-overflow result, and its X (first occurrence wins)
- smp_count, ovf_count  out  CW, CW  number of samples captured, number with overflow
- timeout_err  out  1  sticky watchdog error (constant 0 when the feature is absent)

Behaviour:
- Reset: every output and register is 0; state is IDLE.
  - A reset asserted mid-sweep aborts immediately.
  - sol_start drops asynchronously.
  - No done pulse is produced.
- FSM states: IDLE, ISSUE, ARM, WAIT, RECORD, DONE.
- IDLE: on go, latch the bounds and step, clear all statistics, set x=x_first, go to ISSUE. The busy flag rises in the next cycle.
- ISSUE: sol_start=1 for exactly one cycle with sol_x=x; go to ARM.
- ARM: one cycle in which sol_completed is ignored, so a completion level held over from the previous operation is not mistaken for a new one; go to WAIT.
- WAIT: stay until sol_completed=1, then go to RECORD. Minimum turnaround from start to record is 3 cycles.
- RECORD, single cycle:
  - Register the sample; smp_valid pulses in the following cycle, aligned with the updated statistics.
  - smp_count += 1.
  - If sol_overflow, ovf_count += 1 and the sample is excluded from the minimum.
  - If sol_zero and root_found=0, set root_found=1 and root_x=x.
  - If not overflow and (min_valid=0 or sol_result < min_result, unsigned), update min_result/min_x and set min_valid=1.
  - Next X:
    - If x >= x_last, go to DONE.
    - Else compute nx = x + step with an XW+1-bit sum.
    - If the sum carries out or nx > x_last, go to DONE.
    - Else set x = nx and go to ISSUE.
  - The sweep therefore never wraps.
  - x_first > x_last yields exactly one sample, at x_first.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Statistics hold until the next accepted go.
- A go received while busy is dropped. go coinciding with done is dropped.
- Counters saturate at all-ones.

Optional Feature:
- Macro: EXPRESSION_SWEEP_WATCHDOG_EN.
- When defined:
  - An 8-bit counter runs in WAIT.
  - If it reaches TIMEOUT, set timeout_err=1 (sticky until the next accepted go) and go to DONE. No sample is recorded for that X.
- When undefined: no counter is built, timeout_err is tied to 0, and WAIT is unbounded.

Decomposition:
- Shared package (expression_pkg): FSM state encoding constants, the default widths XW=8 and RW=16, and the TIMEOUT default.
- One natural sub-module: sweep_stats, the combinational/registered update of counts, root and minimum from one sample. The FSM, X stepping and handshake stay in the top.

Test Plan:
- Single-op solver model with completed asserted 2 cycles after start; x_first=3, x_last=3, step=1 -> one sol_start pulse with sol_x=3, smp_count=1, done one cycle after RECORD.
- Range 0..10 step 3 -> samples at X=0,3,6,9 only; smp_count=4; no sol_x beyond 9.
- x_first=250, x_last=255, step=4 -> samples at 250 and 254 only; no wrap to 2.
- Solver model with result=|X-5|, overflow at X=7, range 0..9 step 1 ->
  - root_found=1, root_x=5
  - min_result=0, min_x=5
  - ovf_count=1
- Solver model that holds completed high between operations ->
  - each operation still waits for a fresh completion
  - exactly one sample per start
  - go asserted during the sweep is ignored
- Reset pulled low in WAIT mid-sweep -> all outputs 0 within the same cycle, no done pulse. With EXPRESSION_SWEEP_WATCHDOG_EN and a solver that never completes -> timeout_err=1 and done after TIMEOUT cycles.
